// File: rtl/obi_ssram_arbiter_if.sv
// OBI request/response channel between one master (fetch or LSU) and the SSRAM arbiter.
interface obi_ssram_arbiter_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_ssram_arbiter.sv
// Two-master OBI arbiter in front of one single-port SSRAM.
// Partial-byte stores become a read followed by a merged write (RMW).
module obi_ssram_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter bit          ARB_MODE = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    obi_ssram_arbiter_if.slave   m0,
    obi_ssram_arbiter_if.slave   m1,
    output logic                 csb,
    output logic                 web,
    output logic [ADDR_W-1:0]    addr,
    output logic [31:0]          din,
    input  logic [31:0]          dout
);

    typedef enum logic {IDLE, RMW_WR} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                resp_pending_q, resp_pending_d;
    logic                resp_owner_q, resp_owner_d;
    logic                rmw_owner_q, rmw_owner_d;
    logic [ADDR_W-1:0]   rmw_addr_q, rmw_addr_d;
    logic [3:0]          rmw_be_q, rmw_be_d;
    logic [31:0]         rmw_wdata_q, rmw_wdata_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         din_q;

    logic                gnt0, gnt1;
    logic                win;
    logic [ADDR_W-1:0]   g_addr;
    logic                g_we;
    logic [3:0]          g_be;
    logic [31:0]         g_wdata;

    // Word-offset and above-range address bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0.addr[31:ADDR_W+2], m0.addr[1:0],
                                m1.addr[31:ADDR_W+2], m1.addr[1:0]};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        resp_pending_d = 1'b0;
        resp_owner_d   = resp_owner_q;
        rmw_owner_d    = rmw_owner_q;
        rmw_addr_d     = rmw_addr_q;
        rmw_be_d       = rmw_be_q;
        rmw_wdata_d    = rmw_wdata_q;
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        win            = 1'b0;
        g_addr         = '0;
        g_we           = 1'b0;
        g_be           = '0;
        g_wdata        = '0;
        csb            = 1'b1;
        web            = 1'b1;
        addr           = addr_q;
        din            = din_q;

        unique case (state_q)
            IDLE: begin
                if (!RST && (m0.req || m1.req)) begin
                    if (m0.req && m1.req) win = ARB_MODE ? 1'b1 : ~last_grant_q;
                    else                  win = m1.req;

                    g_addr  = win ? m1.addr[ADDR_W+1:2] : m0.addr[ADDR_W+1:2];
                    g_we    = win ? m1.we    : m0.we;
                    g_be    = win ? m1.be    : m0.be;
                    g_wdata = win ? m1.wdata : m0.wdata;

                    gnt0         = ~win;
                    gnt1         = win;
                    last_grant_d = win;
                    csb          = 1'b0;
                    addr         = g_addr;

                    if (g_we && g_be == 4'hF) begin
                        web            = 1'b0;
                        din            = g_wdata;
                        resp_pending_d = 1'b1;
                        resp_owner_d   = win;
                    end else if (g_we) begin
                        // Partial store: read the old word now, write the merge next cycle.
                        rmw_owner_d = win;
                        rmw_addr_d  = g_addr;
                        rmw_be_d    = g_be;
                        rmw_wdata_d = g_wdata;
                        state_d     = RMW_WR;
                    end else begin
                        resp_pending_d = 1'b1;
                        resp_owner_d   = win;
                    end
                end
            end
            RMW_WR: begin
                csb  = RST;
                web  = 1'b0;
                addr = rmw_addr_q;
                for (int i = 0; i < 4; i++) begin
                    din[8*i +: 8] = rmw_be_q[i] ? rmw_wdata_q[8*i +: 8] : dout[8*i +: 8];
                end
                resp_pending_d = 1'b1;
                resp_owner_d   = rmw_owner_q;
                state_d        = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            resp_pending_q <= 1'b0;
            resp_owner_q   <= 1'b0;
            rmw_owner_q    <= 1'b0;
            rmw_addr_q     <= '0;
            rmw_be_q       <= '0;
            rmw_wdata_q    <= '0;
            addr_q         <= '0;
            din_q          <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            resp_pending_q <= resp_pending_d;
            resp_owner_q   <= resp_owner_d;
            rmw_owner_q    <= rmw_owner_d;
            rmw_addr_q     <= rmw_addr_d;
            rmw_be_q       <= rmw_be_d;
            rmw_wdata_q    <= rmw_wdata_d;
            addr_q         <= addr;
            din_q          <= din;
        end
    end

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = resp_pending_q & ~resp_owner_q;
    assign m1.rvalid = resp_pending_q &  resp_owner_q;
    assign m0.rdata  = dout;
    assign m1.rdata  = dout;

endmodule

// File: tb/tb_obi_ssram_arbiter.sv
// Directed bench: two arbiters (round-robin and LSU-priority), each with a behavioural SSRAM.
module tb_obi_ssram_arbiter;

    typedef struct {
        logic        q;
        logic [31:0] a;
        logic        w;
        logic [3:0]  b;
        logic [31:0] d;
    } req_t;

    // flg = {gnt0, gnt1, rvalid0, rvalid1, csb, web}
    typedef struct {
        req_t        m0;
        req_t        m1;
        logic [5:0]  flg;
        logic [9:0]  addr;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        chk_din;
        logic [31:0] din;
    } vec_t;

    localparam req_t NO = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0};

    function automatic req_t rd(input logic [31:0] a);
        return '{1'b1, a, 1'b0, 4'hF, 32'h0};
    endfunction

    function automatic req_t wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        return '{1'b1, a, 1'b1, b, d};
    endfunction

    logic CLK, RST, preload;
    int   total, bad;

    obi_ssram_arbiter_if ia0 ();
    obi_ssram_arbiter_if ia1 ();
    obi_ssram_arbiter_if ib0 ();
    obi_ssram_arbiter_if ib1 ();

    logic        csb_a, web_a, csb_b, web_b;
    logic [9:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b, dout_a, dout_b;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [5:0]  flg_a, flg_b;

    obi_ssram_arbiter #(.ADDR_W(10), .ARB_MODE(1'b0)) dut_a (
        .CLK(CLK), .RST(RST), .m0(ia0), .m1(ia1),
        .csb(csb_a), .web(web_a), .addr(addr_a), .din(din_a), .dout(dout_a)
    );

    obi_ssram_arbiter #(.ADDR_W(10), .ARB_MODE(1'b1)) dut_b (
        .CLK(CLK), .RST(RST), .m0(ib0), .m1(ib1),
        .csb(csb_b), .web(web_b), .addr(addr_b), .din(din_b), .dout(dout_b)
    );

    assign flg_a = {ia0.gnt, ia1.gnt, ia0.rvalid, ia1.rvalid, csb_a, web_a};
    assign flg_b = {ib0.gnt, ib1.gnt, ib0.rvalid, ib1.rvalid, csb_b, web_b};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural SSRAMs: one-cycle read latency, dout holds across writes and idle cycles.
    always @(posedge CLK) begin
        if (preload) begin
            mem_a[2] <= 32'h1122_3344; mem_a[4] <= 32'hDEAD_BEEF;
            mem_a[5] <= 32'h5555_5555; mem_a[6] <= 32'h6666_6666; mem_a[7] <= 32'h0;
            mem_b[4] <= 32'hDEAD_BEEF; mem_b[5] <= 32'h5555_5555; mem_b[6] <= 32'h6666_6666;
        end else begin
            if (!csb_a) begin
                if (!web_a) mem_a[addr_a] <= din_a;
                else        dout_a <= mem_a[addr_a];
            end
            if (!csb_b) begin
                if (!web_b) mem_b[addr_b] <= din_b;
                else        dout_b <= mem_b[addr_b];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_a(input req_t r0, input req_t r1);
        ia0.req = r0.q; ia0.addr = r0.a; ia0.we = r0.w; ia0.be = r0.b; ia0.wdata = r0.d;
        ia1.req = r1.q; ia1.addr = r1.a; ia1.we = r1.w; ia1.be = r1.b; ia1.wdata = r1.d;
    endtask

    task automatic drive_b(input req_t r0, input req_t r1);
        ib0.req = r0.q; ib0.addr = r0.a; ib0.we = r0.w; ib0.be = r0.b; ib0.wdata = r0.d;
        ib1.req = r1.q; ib1.addr = r1.a; ib1.we = r1.w; ib1.be = r1.b; ib1.wdata = r1.d;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    vec_t vecs [22];

    initial begin
        total = 0;
        bad   = 0;
        drive_a(NO, NO);
        drive_b(NO, NO);
        dout_a  = 32'h0;
        dout_b  = 32'h0;
        RST     = 1'b1;
        preload = 1'b1;

        //          m0                               m1                       flg        addr   rd    rdata          din   din value
        vecs[0]  = '{NO,                             NO,                      6'b000011, 10'd0, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{rd(32'h10),                     NO,                      6'b100001, 10'd4, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[2]  = '{NO,                             NO,                      6'b001011, 10'd4, 1'b1, 32'hDEADBEEF,  1'b0, 32'h0};
        vecs[3]  = '{rd(32'h14),                     rd(32'h18),              6'b010001, 10'd6, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[4]  = '{rd(32'h14),                     rd(32'h10),              6'b100101, 10'd5, 1'b1, 32'h66666666,  1'b0, 32'h0};
        vecs[5]  = '{rd(32'h18),                     rd(32'h10),              6'b011001, 10'd4, 1'b1, 32'h55555555,  1'b0, 32'h0};
        vecs[6]  = '{rd(32'h18),                     rd(32'h14),              6'b100101, 10'd6, 1'b1, 32'hDEADBEEF,  1'b0, 32'h0};
        vecs[7]  = '{NO,                             NO,                      6'b001011, 10'd6, 1'b1, 32'h66666666,  1'b0, 32'h0};
        vecs[8]  = '{wr(32'h1C, 4'hF, 32'hCAFEF00D), NO,                      6'b100000, 10'd7, 1'b0, 32'h0,         1'b1, 32'hCAFEF00D};
        vecs[9]  = '{NO,                             rd(32'h101C),            6'b011001, 10'd7, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[10] = '{NO,                             NO,                      6'b000111, 10'd7, 1'b1, 32'hCAFEF00D,  1'b0, 32'h0};
        vecs[11] = '{NO,                  wr(32'h8, 4'b0010, 32'h0000AB00),   6'b010001, 10'd2, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[12] = '{rd(32'h10),                     rd(32'h14),              6'b000000, 10'd2, 1'b0, 32'h0,         1'b1, 32'h1122AB44};
        vecs[13] = '{rd(32'h10),                     rd(32'h14),              6'b100101, 10'd4, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[14] = '{NO,                             rd(32'h14),              6'b011001, 10'd5, 1'b1, 32'hDEADBEEF,  1'b0, 32'h0};
        vecs[15] = '{rd(32'h8),                      NO,                      6'b100101, 10'd2, 1'b1, 32'h55555555,  1'b0, 32'h0};
        vecs[16] = '{NO,                             NO,                      6'b001011, 10'd2, 1'b1, 32'h1122AB44,  1'b0, 32'h0};
        vecs[17] = '{wr(32'h14, 4'h0, 32'hFFFFFFFF), NO,                      6'b100001, 10'd5, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[18] = '{NO,                             NO,                      6'b000000, 10'd5, 1'b0, 32'h0,         1'b1, 32'h55555555};
        vecs[19] = '{NO,                             NO,                      6'b001011, 10'd5, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[20] = '{NO,                             rd(32'h14),              6'b010001, 10'd5, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[21] = '{NO,                             NO,                      6'b000111, 10'd5, 1'b1, 32'h55555555,  1'b0, 32'h0};

        repeat (3) @(posedge CLK);
        preload = 1'b0;
        #1;
        check("reset flg_a", {26'h0, flg_a}, {26'h0, 6'b000011});
        check("reset addr_a", {22'h0, addr_a}, 32'h0);
        check("reset din_a", din_a, 32'h0);
        next_cycle();
        RST = 1'b0;

        // Idle after reset: no grants, no responses, SSRAM deselected.
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check($sformatf("idle%0d flg_a", c), {26'h0, flg_a}, {26'h0, 6'b000011});
            check($sformatf("idle%0d flg_b", c), {26'h0, flg_b}, {26'h0, 6'b000011});
            next_cycle();
        end

        // Round-robin arbiter: one vector per cycle.
        for (int i = 0; i < 22; i++) begin
            drive_a(vecs[i].m0, vecs[i].m1);
            @(negedge CLK);
            check($sformatf("v%0d flg", i), {26'h0, flg_a}, {26'h0, vecs[i].flg});
            check($sformatf("v%0d addr", i), {22'h0, addr_a}, {22'h0, vecs[i].addr});
            if (vecs[i].chk_rd)
                check($sformatf("v%0d rdata", i), vecs[i].flg[3] ? ia0.rdata : ia1.rdata, vecs[i].rdata);
            if (vecs[i].chk_din)
                check($sformatf("v%0d din", i), din_a, vecs[i].din);
            next_cycle();
        end
        drive_a(NO, NO);

        // LSU-priority arbiter: m1 wins every contended cycle, m0 only once m1 drops.
        drive_b(rd(32'h10), rd(32'h14));
        @(negedge CLK);
        check("prio c1 flg", {26'h0, flg_b}, {26'h0, 6'b010001});
        check("prio c1 addr", {22'h0, addr_b}, 32'd5);
        next_cycle();
        drive_b(rd(32'h10), rd(32'h18));
        @(negedge CLK);
        check("prio c2 flg", {26'h0, flg_b}, {26'h0, 6'b010101});
        check("prio c2 rdata", ib1.rdata, 32'h55555555);
        next_cycle();
        drive_b(rd(32'h10), rd(32'h14));
        @(negedge CLK);
        check("prio c3 flg", {26'h0, flg_b}, {26'h0, 6'b010101});
        check("prio c3 rdata", ib1.rdata, 32'h66666666);
        next_cycle();
        drive_b(rd(32'h10), NO);
        @(negedge CLK);
        check("prio c4 flg", {26'h0, flg_b}, {26'h0, 6'b100101});
        check("prio c4 addr", {22'h0, addr_b}, 32'd4);
        next_cycle();
        drive_b(NO, NO);
        @(negedge CLK);
        check("prio c5 flg", {26'h0, flg_b}, {26'h0, 6'b001011});
        check("prio c5 rdata", ib0.rdata, 32'hDEADBEEF);
        next_cycle();

        // Reset in the middle of an RMW: the merged write and its response are dropped.
        drive_a(NO, wr(32'h8, 4'b0001, 32'h000000EE));
        @(negedge CLK);
        check("rst rmw grant", {26'h0, flg_a}, {26'h0, 6'b010001});
        next_cycle();
        drive_a(NO, NO);
        @(negedge CLK);
        check("rst rmw wr phase", {26'h0, flg_a}, {26'h0, 6'b000000});
        RST = 1'b1;
        #1;
        check("rst rmw abort", {26'h0, flg_a}, {26'h0, 6'b000011});
        drive_a(rd(32'h8), rd(32'h10));
        #1;
        check("rst no grant", {26'h0, flg_a}, {26'h0, 6'b000011});
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        check("post rst flg", {26'h0, flg_a}, {26'h0, 6'b100001});
        check("post rst addr", {22'h0, addr_a}, 32'd2);
        next_cycle();
        drive_a(NO, rd(32'h10));
        @(negedge CLK);
        check("post rst flg2", {26'h0, flg_a}, {26'h0, 6'b011001});
        check("post rst word", ia0.rdata, 32'h1122AB44);
        next_cycle();
        drive_a(NO, NO);
        @(negedge CLK);
        check("post rst flg3", {26'h0, flg_a}, {26'h0, 6'b000111});
        check("post rst rdata", ia1.rdata, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obi_ssram_arbiter.md
Name: obi_ssram_arbiter

Overview:
- Shares one single-port SSRAM (sram_32_1024_freepdk45 style: csb/web/addr/din/dout, 1-cycle read latency, no write mask) between two OBI masters: master 0 = fetch, master 1 = LSU.
- Arbitrates requests and issues grants.
- Sequences read-modify-write for partial-byte stores.
- Routes each response back to the master that was granted.
- Sits between riscv_core and the memory macro; used when a unified instruction/data memory replaces the two per-port ssram_wrap instances.

Parameters:
ADDR_W, 10, SSRAM word-address width
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority to master 1 (LSU)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 OBI request
m0_gnt  out  1  master 0 grant (combinational)
m0_addr  in  32  master 0 byte address
m0_we  in  1  master 0 write enable
m0_be  in  4  master 0 byte enables
m0_wdata  in  32  master 0 write data
m0_rvalid  out  1  master 0 response valid
m0_rdata  out  32  master 0 read data
m1_req, m1_gnt, m1_addr, m1_we, m1_be, m1_wdata, m1_rvalid, m1_rdata  same widths/directions, master 1
csb  out  1  SSRAM chip select, active low
web  out  1  SSRAM write enable, active low
addr  out  ADDR_W  SSRAM word address = granted mX_addr[ADDR_W+1:2]
din  out  32  SSRAM write data
dout  in  32  SSRAM read data, valid the cycle after a read access

Behaviour:
- States: IDLE, RMW_WR.
- Reset values (asynchronous, while RST=1):
  - state = IDLE, last_grant = 1 (so master 0 wins the first round-robin tie), resp_pending = 0.
  - All gnt and rvalid = 0; csb = 1, web = 1, addr = 0, din = 0.

IDLE, arbitration (combinational):
- Only one requester: that requester wins.
- Both requesting, ARB_MODE=0: the master not equal to last_grant wins.
- Both requesting, ARB_MODE=1: master 1 wins.
- Winner sees gnt=1 in the same cycle; the loser sees gnt=0 and must hold its request. OBI requires req/addr/we/be/wdata stable until gnt.
- last_grant updates on every grant, in both modes.

IDLE, access issue (same cycle as gnt):
- Read (we=0): csb=0, web=1. Byte enables are ignored; the full word is returned.
- Full write (we=1, be=4'b1111): csb=0, web=0, din=wdata.
- Partial write (we=1, be≠4'b1111, including be=0):
  - Issue a read: csb=0, web=1.
  - Register owner, word address, be and wdata; go to RMW_WR.

RMW_WR (exactly 1 cycle):
- Drive csb=0, web=0, addr = registered address.
- din per byte i = be[i] ? wdata[8i+7:8i] : dout[8i+7:8i].
- No grants in this cycle; both gnt=0.
- Return to IDLE.

Responses:
- mX_rvalid=1 for exactly one cycle, only for the owning master.
- Timing for a grant at cycle T:
  - Read: rvalid at T+1.
  - Full write: rvalid at T+1.
  - Partial write: rvalid at T+2 (the cycle after RMW_WR).
- m0_rdata = m1_rdata = dout at all times; data is meaningful only when rvalid=1 and the transaction was a read.
- Throughput is one transaction per cycle for reads and full writes. A new grant may coincide with the rvalid of the previous one.
- Exception: the cycle in which a partial-write rvalid is issued (IDLE after RMW_WR) may also carry a new grant.

Idle cycles (no grant and not in RMW_WR):
- csb=1, web=1; addr and din hold their last values.

Boundary rules:
- Simultaneous req from both masters while in RMW_WR: neither is granted; arbitration resumes in IDLE the next cycle with last_grant unchanged.
- Address bits above ADDR_W+1 are ignored (the address wraps modulo 2^ADDR_W words). Bits [1:0] are ignored.
- RST asserted mid-RMW or with a response pending: the pending write and response are dropped; no rvalid is issued after reset release.
- No request is granted while RST=1.

Test Plan:
1. Reset then idle, no req → all gnt/rvalid=0, csb=1, web=1 through 10 cycles.
2. m0 read 0x0000_0010 alone, SSRAM word 4 = 0xDEADBEEF → m0_gnt same cycle, addr=4, web=1; m0_rvalid next cycle with rdata 0xDEADBEEF; m1_rvalid stays 0.
3. ARB_MODE=0, both req reads, held for 4 cycles → grants alternate m0, m1, m0, m1; rvalid follows each one cycle later to the matching master.
4. ARB_MODE=1, both req continuously → m1 granted every cycle; m0_gnt=0 until m1_req drops, then m0 granted that cycle.
5. m1 write addr 0x8, be=4'b0010, wdata=0x0000AB00, word 2 = 0x11223344 → cycle T read, T+1 write din=0x1122AB44 with no grants, m1_rvalid at T+2; later read returns 0x1122AB44.
6. Assert RST during RMW_WR → no write, no rvalid; after release word unchanged, first grant goes to m0 on contention.
